io_edge_monitor: RTL

IO_EDGE_MONITOR -- requirements
Module: io_edge_monitor

---
 rtl/io_edge_monitor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/io_edge_monitor.sv
// io_edge_monitor: four-lane pad edge counter behind a Wishbone slave port.
// Define IO_EDGE_FALL_EN to build the CTRL.FALL falling-edge mode.

module io_edge_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  input  logic             en,
  input  logic             fall,
  input  logic             cnt_clr,
  input  logic             edge_w1c,
  input  logic             ovf_w1c,
  output logic             level,
  output logic [CNT_W-1:0] cnt,
  output logic             edge_st,
  output logic             ovf_st
);
  logic       s1, s2, prev, det_q, inc;
  // vld_pipe[2] marks prev as holding a real post-reset sample
  logic [2:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      det_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= pin;
      s2       <= s1;
      prev     <= s2;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      det_q    <= vld_pipe[2] & (fall ? (prev & ~s2) : (s2 & ~prev));
    end
  end

  // a clear in the same cycle drops the edge entirely
  assign inc   = en & det_q & ~cnt_clr;
  assign level = s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      edge_st <= 1'b0;
      ovf_st  <= 1'b0;
    end else begin
      if (cnt_clr)  cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
      if (inc)           edge_st <= 1'b1;
      else if (edge_w1c) edge_st <= 1'b0;
      if (inc && &cnt)  ovf_st <= 1'b1;
      else if (ovf_w1c) ovf_st <= 1'b0;
    end
  end
endmodule

module io_edge_monitor #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  io_in,
  output logic        irq
);
  localparam int NUM_LANES = 4;

  logic                            en, fall;
  logic [3:0]                      mask;
  logic                            hit, acc, wr, clr01, clr23, w1c;
  logic [2:0]                      off;
  logic [31:0]                     rdata;
  logic [NUM_LANES-1:0]            level, edge_st, ovf_st;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
  logic [NUM_LANES-1:0][15:0]      cnt16;
  logic                            unused_ok;

  assign hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc   = hit & ~wbs_ack_o;
  assign wr    = acc & wbs_we_i;
  assign off   = wbs_adr_i[4:2];
  assign clr01 = wr && off == 3'd2 && |wbs_sel_i;
  assign clr23 = wr && off == 3'd3 && |wbs_sel_i;
  assign w1c   = wr && off == 3'd1 && wbs_sel_i[1];
  assign unused_ok = ^{wbs_dat_i[31:16], wbs_dat_i[3:1], wbs_adr_i[7:5], wbs_adr_i[1:0]};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      io_edge_lane #(.CNT_W(CNT_W)) u_lane (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .pin      (io_in[i]),
        .en       (en),
        .fall     (fall),
        .cnt_clr  ((i < 2) ? clr01 : clr23),
        .edge_w1c (w1c & wbs_dat_i[8+i]),
        .ovf_w1c  (w1c & wbs_dat_i[12+i]),
        .level    (level[i]),
        .cnt      (cnt[i]),
        .edge_st  (edge_st[i]),
        .ovf_st   (ovf_st[i])
      );
      assign cnt16[i] = 16'(cnt[i]);
    end
  endgenerate

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en   <= 1'b0;
      mask <= '0;
    end else if (wr && off == 3'd0 && wbs_sel_i[0]) begin
      en   <= wbs_dat_i[0];
      mask <= wbs_dat_i[7:4];
    end
  end

`ifdef IO_EDGE_FALL_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                                 fall <= 1'b0;
    else if (wr && off == 3'd0 && wbs_sel_i[0])   fall <= wbs_dat_i[1];
  end
`else
  assign fall = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = {24'b0, mask, 2'b0, fall, en};
      3'd1:    rdata = {16'b0, ovf_st, edge_st, 4'b0, level};
      3'd2:    rdata = {cnt16[1], cnt16[0]};
      3'd3:    rdata = {cnt16[3], cnt16[2]};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : 32'h0;
      irq       <= |(edge_st & mask);
    end
  end
endmodule
